// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one iteration counter, with a one-cycle register-file write-back.
module rv_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            wb_we,
    output logic [4:0]      wb_waddr,
    output logic [XLEN-1:0] wb_wdata
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic            signA_q, signA_d;
    logic            signB_q, signB_d;
    logic            bZero_q, bZero_d;
    logic [XLEN-1:0] accHi_q, accHi_d;
    logic [XLEN-1:0] accLo_q, accLo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            we_q, we_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            signedA, signedB, negA, negB;
    logic [XLEN-1:0] magA, magB;
    logic            isDiv;
    logic [XLEN-1:0] mulAdd;
    logic [XLEN:0]   mulSum;
    logic [XLEN:0]   divShift;
    logic            divGeq;
    logic [XLEN-1:0] divSub;
    logic [XLEN-1:0] stepHi, stepLo;
    logic [2*XLEN-1:0] prod, prodFix;
    logic [XLEN-1:0] mulRes, quotFix, remFix, divRes, result;

    // Accept-time operand conditioning: signed operands become magnitude + sign flag.
    always_comb begin
        signedA = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        signedB = signedA && (funct3 != 3'b010);
        negA    = signedA && rs1_val[XLEN-1];
        negB    = signedB && rs2_val[XLEN-1];
        magA    = negA ? ('0 - rs1_val) : rs1_val;
        magB    = negB ? ('0 - rs2_val) : rs2_val;
    end

    // Multiply keeps the multiplier in accLo and adds opnd into accHi; divide shifts the
    // dividend out of accLo into the partial remainder in accHi, quotient bits fill accLo.
    always_comb begin
        isDiv    = f3_q[2];
        mulAdd   = accLo_q[0] ? opnd_q : '0;
        mulSum   = {1'b0, accHi_q} + {1'b0, mulAdd};
        divShift = {accHi_q, accLo_q[XLEN-1]};
        divGeq   = (divShift >= {1'b0, opnd_q});
        divSub   = divShift[XLEN-1:0] - opnd_q;
        if (isDiv) begin
            stepHi = divGeq ? divSub : divShift[XLEN-1:0];
            stepLo = {accLo_q[XLEN-2:0], divGeq};
        end else begin
            stepHi = mulSum[XLEN:1];
            stepLo = {mulSum[0], accLo_q[XLEN-1:1]};
        end
    end

    // Sign fix applied to the final iteration's values; a zero divisor keeps the
    // all-ones quotient and the remainder naturally reproduces the dividend.
    always_comb begin
        prod    = {stepHi, stepLo};
        prodFix = (signA_q ^ signB_q) ? ('0 - prod) : prod;
        mulRes  = (f3_q[1:0] == 2'b00) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
        quotFix = ((signA_q ^ signB_q) && !bZero_q) ? ('0 - stepLo) : stepLo;
        remFix  = signA_q ? ('0 - stepHi) : stepHi;
        divRes  = f3_q[1] ? remFix : quotFix;
        result  = isDiv ? divRes : mulRes;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        signA_d = signA_q;
        signB_d = signB_q;
        bZero_d = bZero_q;
        accHi_d = accHi_q;
        accLo_d = accLo_q;
        opnd_d  = opnd_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    f3_d    = funct3;
                    rd_d    = rd;
                    signA_d = negA;
                    signB_d = negB;
                    bZero_d = (rs2_val == '0);
                    accHi_d = '0;
                    accLo_d = funct3[2] ? magA : magB;
                    opnd_d  = funct3[2] ? magB : magA;
                end
            end
            CALC: begin
                accHi_d = stepHi;
                accLo_d = stepLo;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    wdata_d = result;
                    waddr_d = rd_q;
                    we_d    = (rd_q != 5'd0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            bZero_q <= 1'b0;
            accHi_q <= '0;
            accLo_q <= '0;
            opnd_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            signA_q <= signA_d;
            signB_q <= signB_d;
            bZero_q <= bZero_d;
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            opnd_q  <= opnd_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign wb_we    = we_q;
    assign wb_waddr = waddr_q;
    assign wb_wdata = wdata_q;

endmodule
